// File: rtl/pipeline_pkg.sv
// Shared types for the hazard scheduler: in-flight slot record, scheduler states,
// operand-forwarding select encodings and the slot match helpers.
package pipeline_pkg;

    localparam int REG_IDX_W = 3;
    localparam int CNT_W     = 3;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dst;
        logic                 wb;
        logic                 mem_read;
    } slot_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

    // A source depends on a slot only if it is read and the slot will write that register.
    function automatic logic slot_hit(input slot_t slot, input logic used,
                                      input logic [REG_IDX_W-1:0] src);
        return used && slot.valid && slot.wb && (slot.dst == src);
    endfunction

    function automatic fwd_sel_e pick_youngest(input logic hit_ex, input logic hit_mem,
                                               input logic hit_wb);
        if (hit_ex)  return FWD_EX;
        if (hit_mem) return FWD_MEM;
        if (hit_wb)  return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-stage record of in-flight instructions (EX -> MEM -> WB) that the
// hazard scheduler compares decode sources against.
module hazard_slot_pipe
    import pipeline_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  slot_t slot_i,
    output slot_t ex_o,
    output slot_t mem_o,
    output slot_t wb_o
);

    slot_t ex_q, mem_q, wb_q;

    // NOTE: non-blocking assignments let every stage capture its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= slot_i;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: RAW stall detection, taken-jump flush sequencing
// and optional operand forwarding, compiled in by defining HAZARD_FWD_EN.
module hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int NUM_REGS     = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dec_valid,
    input  logic [$clog2(NUM_REGS)-1:0] dec_src1,
    input  logic [$clog2(NUM_REGS)-1:0] dec_src2,
    input  logic                        dec_src1_used,
    input  logic                        dec_src2_used,
    input  logic [$clog2(NUM_REGS)-1:0] dec_dst,
    input  logic                        dec_wb,
    input  logic                        dec_mem_read,
    input  logic                        jump_occured,
    output logic                        stall,
    output logic                        flush,
    output logic                        issue,
    output logic [1:0]                  fwd_sel1,
    output logic [1:0]                  fwd_sel2
);

    slot_t                ex_s, mem_s, wb_s, ex_load;
    sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [REG_IDX_W-1:0] src1, src2;
    logic                 hit1_ex, hit1_mem, hit1_wb;
    logic                 hit2_ex, hit2_mem, hit2_wb;
    logic                 hazard, in_run, jump_take;

    assign src1 = REG_IDX_W'(dec_src1);
    assign src2 = REG_IDX_W'(dec_src2);

    assign hit1_ex  = slot_hit(ex_s,  dec_src1_used, src1);
    assign hit1_mem = slot_hit(mem_s, dec_src1_used, src1);
    assign hit1_wb  = slot_hit(wb_s,  dec_src1_used, src1);
    assign hit2_ex  = slot_hit(ex_s,  dec_src2_used, src2);
    assign hit2_mem = slot_hit(mem_s, dec_src2_used, src2);
    assign hit2_wb  = slot_hit(wb_s,  dec_src2_used, src2);

`ifdef HAZARD_FWD_EN
    // Only load data still in EX cannot be bypassed; everything older is forwarded.
    assign hazard   = ex_s.mem_read && (hit1_ex || hit2_ex);
    assign fwd_sel1 = pick_youngest(hit1_ex, hit1_mem, hit1_wb);
    assign fwd_sel2 = pick_youngest(hit2_ex, hit2_mem, hit2_wb);
`else
    assign hazard   = hit1_ex | hit1_mem | hit1_wb | hit2_ex | hit2_mem | hit2_wb;
    assign fwd_sel1 = FWD_RF;
    assign fwd_sel2 = FWD_RF;
`endif

    assign in_run    = (state_q == RUN);
    assign jump_take = in_run && jump_occured;

    // Gating with reset clears flush/issue the moment reset drops, even mid-flush.
    assign flush = reset && (jump_take || !in_run);
    assign stall = hazard && !flush;
    assign issue = reset && dec_valid && !hazard && in_run && !jump_occured;

    always_comb begin
        ex_load          = '0;
        ex_load.valid    = issue;
        ex_load.dst      = REG_IDX_W'(dec_dst);
        ex_load.wb       = dec_wb;
        ex_load.mem_read = dec_mem_read;
    end

    hazard_slot_pipe u_slots (
        .clk    (clk),
        .reset  (reset),
        .slot_i (ex_load),
        .ex_o   (ex_s),
        .mem_o  (mem_s),
        .wb_o   (wb_s)
    );

    // The jump cycle is the first of FLUSH_CYCLES flush cycles; FLUSH covers the rest.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (jump_occured) begin
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end
            end
            FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
